// File: rtl/svm_pkg.sv
// -----------------------------------------------------------------------------
// svm_pkg
// Shared definitions for the 6-class linear SVM classifier.
//   - Class count and accumulator width.
//   - Weight, bias, accumulator and class-index types.
//   - Trained coefficient tables W[class][feature] and B[class]. These come from
//     the model-generation flow. Regenerate them there and do not hand-edit.
// -----------------------------------------------------------------------------
package svm_pkg;

    localparam int N_classes    = 6;
    localparam int N_FEATURES   = 33;
    localparam int INPUT_W      = 4;
    localparam int WEIGHT_W     = 4;
    localparam int BIAS_W       = 4;
    localparam int FEATURE_BITS = 6;
    localparam int CLASS_W      = 3;

    // The worst-case sum is 33 * 15 * 8 + 8 = 3968. This fits in a 14-bit
    // signed range, so the accumulators need no saturation logic.
    localparam int ACC_W = INPUT_W + WEIGHT_W + FEATURE_BITS;

    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef logic signed [BIAS_W-1:0]   bias_t;
    typedef logic signed [ACC_W-1:0]    acc_t;
    typedef logic        [CLASS_W-1:0]  class_t;

    localparam weight_t W [N_classes][N_FEATURES] = '{
        '{ 2, -1,  3,  0, -4,  5,  1, -2,  6, -7,  0,  3, -3,  2, -5,  4,  1,
          -1,  7, -8,  2,  0, -2,  3, -6,  5,  1, -4,  2, -1,  0,  6, -3},
        '{ 1,  4, -2,  5, -1,  0, -6,  3,  2, -3,  7, -4,  1,  0, -2,  6, -5,
           3, -1,  2, -7,  4,  0,  1, -3,  5, -8,  2,  3, -2,  4, -1,  1},
        '{ 7, -3,  0,  2,  6, -1, -4,  5,  0,  3, -2,  1, -6,  4,  2, -5,  0,
           7, -3,  1,  5, -2, -1,  4,  0, -7,  3,  2, -4,  6,  1, -1,  2},
        '{-2,  0,  5, -3,  1,  4, -2, -6,  3,  7, -1,  2,  0, -4,  6, -3,  2,
          -5,  1,  0,  3, -1,  6, -2,  4, -8,  0,  5, -3,  1,  2, -7,  4},
        '{ 7,  2, -4,  1, -3,  6,  0, -1,  5, -2,  3, -6,  4,  1, -7,  0,  2,
          -3,  5, -4,  1,  7, -5,  0,  2, -1,  6, -3, -2,  4,  0,  3, -6},
        '{-8,  5,  1, -5,  3, -2,  7,  0, -4,  1,  6, -3,  2, -1,  4, -6,  3,
           0, -2,  5, -1, -3,  4,  6, -5,  2, -1,  0,  7, -4,  3, -2, -1}
    };

    localparam bias_t B [N_classes] = '{-3, 1, 5, 2, 5, -8};

endpackage

// File: rtl/svm_argmax.sv
// -----------------------------------------------------------------------------
// svm_argmax
// Combinational 6-way signed maximum. On a tie, the lowest class index wins.
// Ports:
//   score_i : per-class signed scores
//   idx_o   : index of the winning class (0..5)
// -----------------------------------------------------------------------------
module svm_argmax
    import svm_pkg::*;
(
    input  acc_t   score_i [N_classes],
    output class_t idx_o
);

    acc_t best;

    // NOTE: every variable driven here gets a value before any conditional
    // update. Without that default, the synthesis tool infers a latch.
    always_comb begin
        best  = score_i[0];
        idx_o = '0;
        for (int c = 1; c < N_classes; c++) begin
            // A strict greater-than keeps the earlier (lower) index on a tie.
            if (score_i[c] > best) begin
                best  = score_i[c];
                idx_o = class_t'(c);
            end
        end
    end

endmodule

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top
// Sequential one-vs-rest linear SVM. Each clock processes one feature, and all
// six class accumulators add w[c][cnt] * x[cnt] in parallel. After the last
// feature, the argmax of (accumulator + bias) is registered into w_class and
// ready is raised. Both outputs then hold until the next reset. A reset pulse
// starts a new sample.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset. It aborts any evaluation and
//             restarts it.
//   in      : packed unsigned features. Feature i is
//             in[i*inputWidth +: inputWidth]. The input must be held stable
//             until ready.
//   ready   : result-valid flag. It rises on the 34th edge after reset release.
//   w_class : index of the winning class (0..5)
// -----------------------------------------------------------------------------
module top
    import svm_pkg::*;
#(
    parameter int weightWidth  = 4,
    parameter int feature_bits = 6,
    parameter int N_features   = 33,
    parameter int biasWidth    = 4,
    parameter int inputWidth   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_features*inputWidth-1:0] in,
    output logic                             ready,
    output logic [2:0]                       w_class
);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

    localparam logic [feature_bits-1:0] LAST_CNT = feature_bits'(N_features);

    state_e                  state_q, state_d;
    logic [feature_bits-1:0] cnt_q, cnt_d;
    acc_t                    acc_q [N_classes];
    acc_t                    acc_d [N_classes];
    logic                    ready_q, ready_d;
    class_t                  w_class_q, w_class_d;

    logic                    feat_active;
    logic [feature_bits-1:0] feat_idx;
    logic [inputWidth-1:0]   x_sel;
    acc_t                    x_ext;
    acc_t                    prod  [N_classes];
    acc_t                    score [N_classes];
    class_t                  arg_idx;

    // Once cnt reaches N_features, the index is parked at 0. This keeps the
    // feature and weight lookups in range during the final compare cycle.
    assign feat_active = (cnt_q < LAST_CNT);
    assign feat_idx    = feat_active ? cnt_q : '0;
    assign x_sel       = in[feat_idx*inputWidth +: inputWidth];

    // Features are unsigned, so they are zero-extended before the signed
    // multiply.
    assign x_ext = acc_t'(x_sel);

    always_comb begin
        for (int c = 0; c < N_classes; c++) begin
            prod[c]  = x_ext * acc_t'(signed'(W[c][feat_idx][weightWidth-1:0]));
            // The bias is sign-extended and added at product-LSB alignment.
            // It is applied only at the compare, so the accumulators start
            // from zero.
            score[c] = acc_q[c] + acc_t'(signed'(B[c][biasWidth-1:0]));
        end
    end

    svm_argmax u_argmax (
        .score_i (score),
        .idx_o   (arg_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        w_class_d = w_class_q;
        for (int c = 0; c < N_classes; c++) begin
            acc_d[c] = acc_q[c];
        end

        unique case (state_q)
            RUN: begin
                if (feat_active) begin
                    for (int c = 0; c < N_classes; c++) begin
                        acc_d[c] = acc_q[c] + prod[c];
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    w_class_d = arg_idx;
                    ready_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // Hold the result until reset.
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: state registers take non-blocking assignments only. This way, every
    // flop samples values from before the edge, whatever the process order.
    // The accumulator array is a small bank of flops, not a RAM, so each
    // element takes the asynchronous reset. A restart must begin from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            w_class_q <= '0;
            for (int c = 0; c < N_classes; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            w_class_q <= w_class_d;
            for (int c = 0; c < N_classes; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign ready   = ready_q;
    assign w_class = w_class_q;

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top
// Self-checking bench for top. Expected classes come from an integer
// reference model of the linear SVM, which is evaluated from the package
// coefficients.
// -----------------------------------------------------------------------------
module tb_top;
    import svm_pkg::*;

    localparam int NF  = 33;
    localparam int IW  = 4;
    localparam int NIN = NF * IW;

    logic           clk;
    logic           rst_n;
    logic [NIN-1:0] in_s;
    logic           ready;
    logic [2:0]     w_class;

    int checks;
    int errors;

    top #(
        .weightWidth  (4),
        .feature_bits (6),
        .N_features   (NF),
        .biasWidth    (4),
        .inputWidth   (IW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in_s),
        .ready   (ready),
        .w_class (w_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference model: score[c] = B[c] + sum_i W[c][i] * x[i], in plain
    // integers. The highest score wins, and the first class wins a tie.
    function automatic int model_class(input logic [NIN-1:0] x);
        int score;
        int best;
        int best_idx;
        best     = 0;
        best_idx = 0;
        for (int c = 0; c < N_classes; c++) begin
            score = int'(B[c]);
            for (int i = 0; i < NF; i++) begin
                score += int'(W[c][i]) * int'(x[i*IW +: IW]);
            end
            if (c == 0 || score > best) begin
                best     = score;
                best_idx = c;
            end
        end
        return best_idx;
    endfunction

    function automatic logic [NIN-1:0] rand_x();
        logic [NIN-1:0] x;
        for (int i = 0; i < NF; i++) begin
            x[i*IW +: IW] = IW'($urandom_range(0, 15));
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Call this task with rst_n low, just after a negative clock edge.
    // It releases reset there and checks that ready stays low for 33 rising
    // edges and is high on the 34th. It then checks the class.
    task automatic release_and_check(input logic [NIN-1:0] x, input string tag);
        int early;
        rst_n = 1'b1;
        early = 0;
        repeat (33) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) early++;
        end
        check({tag, " ready_early"}, early, 0);
        @(posedge clk);
        #1;
        check({tag, " ready_at_34"}, {31'b0, ready}, 1);
        check({tag, " w_class"}, {29'b0, w_class}, model_class(x));
    endtask

    task automatic run_sample(input logic [NIN-1:0] x, input string tag);
        @(negedge clk);
        in_s  = x;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        release_and_check(x, tag);
    endtask

    initial begin
        logic [NIN-1:0] x;
        logic [NIN-1:0] x2;
        int             exp_cls;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        in_s   = rand_x();

        // Check the outputs while reset is held for two cycles.
        repeat (2) @(negedge clk);
        check("reset ready", {31'b0, ready}, 0);
        check("reset w_class", {29'b0, w_class}, 0);

        // Zero input: the scores equal the biases, and classes 2 and 4 tie.
        // Check the 34-edge latency, then check that the result holds.
        x = '0;
        in_s = x;
        @(negedge clk);
        release_and_check(x, "zero");
        exp_cls = model_class(x);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("zero hold ready", {31'b0, ready}, 1);
            check("zero hold w_class", {29'b0, w_class}, exp_cls);
        end

        // Set feature 0 to full scale and all others to zero. Classes 2 and 4
        // tie on the top score, so the lower index must win.
        x = '0;
        x[IW-1:0] = 4'hF;
        run_sample(x, "tie_f0");

        // All features at full scale: the largest magnitude sums.
        x = '1;
        run_sample(x, "all_max");

        // Mid-operation reset: abort after 10 edges, then restart on the same
        // input. The result must match an uninterrupted run.
        x = rand_x();
        @(negedge clk);
        in_s  = x;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset ready", {31'b0, ready}, 0);
        @(negedge clk);
        @(negedge clk);
        release_and_check(x, "midreset");

        // Back-to-back: while ready is high, assert reset away from any edge.
        // ready and w_class must clear at once. Then release on a negative
        // edge and run the new sample.
        x = rand_x();
        run_sample(x, "b2b_first");
        x2 = rand_x();
        @(posedge clk);
        #3;
        in_s  = x2;
        rst_n = 1'b0;
        #1;
        check("b2b async ready", {31'b0, ready}, 0);
        check("b2b async w_class", {29'b0, w_class}, 0);
        @(negedge clk);
        release_and_check(x2, "b2b_second");

        // Randomized regression against the reference model.
        for (int n = 0; n < 20; n++) begin
            x = rand_x();
            run_sample(x, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- weightWidth, 4, signed two's-complement SVM weight width
- feature_bits, 6, width of the feature-index counter
- N_features, 33, number of input features
- biasWidth, 4, signed two's-complement bias width
- inputWidth, 4, unsigned width of each feature
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising-edge active
- rst_n, in, 1, asynchronous active-low reset
- in, in, N_features*inputWidth (132), packed features; feature i = in[i*inputWidth +: inputWidth]
- ready, out, 1, result-valid flag
- w_class, out, 3, winning class index 0..5
REQ-003 Internal localparams SHALL be N_classes=6 and accumulator width ACC_W = inputWidth+weightWidth+feature_bits = 14, signed.

Function
REQ-004 Classifier SHALL be a linear one-vs-rest SVM: score[c] = bias[c] + sum over i of w[c][i]*x[i], for c = 0..5.
REQ-005 x[i] SHALL be unsigned; w and bias SHALL be signed; products SHALL be sign-correct, with the unsigned x zero-extended before multiplying.
REQ-006 bias[c] SHALL be sign-extended to ACC_W at product-LSB alignment, with no shift.
REQ-007 Evaluation SHALL be sequential, one feature per clock: a counter cnt (feature_bits wide) selects x[cnt], and all 6 accumulators add w[c][cnt]*x[cnt] in parallel.
REQ-008 FSM states SHALL be RUN and DONE, and RUN SHALL be entered from reset.
- RUN with cnt < N_features: accumulate, then cnt++.
- RUN with cnt == N_features: register argmax(score) into w_class, set ready=1, go to DONE.
- DONE: hold w_class and ready, with no further accumulation, until reset.
REQ-009 Latency: ready SHALL rise on the (N_features+1)th = 34th rising clk edge after rst_n deasserts.
REQ-010 Argmax SHALL compare signed scores; on a tie, the lowest class index SHALL win.
REQ-011 Input `in` SHALL be sampled combinationally each cycle; the environment holds it stable from rst_n release until ready.
REQ-012 Accumulation SHALL NOT overflow: ACC_W covers 33 × max|product| plus bias, and no saturation logic is required.
REQ-013 A new sample SHALL be started only by a reset pulse; there is no start or accept handshake.

Reset
REQ-014 rst_n low SHALL asynchronously clear cnt=0, all accumulators=0, ready=0, w_class=0, and state=RUN.
REQ-015 Reset asserted mid-operation SHALL abort the current evaluation; after release, a full 34-cycle evaluation SHALL restart.
REQ-016 Reset asserted while in DONE SHALL drop ready to 0 immediately (asynchronously).

Structure
REQ-017 A shared package (svm_pkg) SHALL hold the following: N_classes, ACC_W, the weight constant array W[6][33] (weightWidth signed), the bias constant array B[6] (biasWidth signed), and typedefs for the weight, bias and accumulator types.
REQ-018 The trained coefficients SHALL come from the model-generation flow; RTL SHALL reference them only through the package.
REQ-019 One sub-module SHALL exist: svm_argmax, a combinational 6-way signed max that outputs the 3-bit index with the lowest-index tie rule.
REQ-020 The MAC datapath and the FSM SHALL reside in top.

Verification
REQ-021 Reset check: hold rst_n=0 for 2 cycles with any input -> ready=0 and w_class=0.
REQ-022 Latency check: in = all zeros, release rst_n -> ready=0 for 33 edges and ready=1 at edge 34; w_class = argmax(B) with lowest-index tie-break, and it stays constant for 10 further cycles.
REQ-023 Mid-operation reset: pulse rst_n low at cycle 10, then release -> ready rises exactly 34 edges after the second release, and the result equals an uninterrupted run on the same input.
REQ-024 Tie rule: choose an input where score[2]==score[4] are the maximum (found from a golden model) -> w_class=2.
REQ-025 Dataset regression: for each line of inputs.txt (132-bit binary, then the class), run reset -> wait for ready -> compare w_class to the golden fixed-point model -> 100% match with the model; log the accuracy versus the labels.
REQ-026 Back-to-back samples: reset while ready=1, release on a negative clock edge -> ready falls immediately, and the next result is correct for the new input.
